// File: rtl/period_meter_if.sv
// Handshake and result bundle for period_meter: stimulus/control toward the meter,
// measurement results and status back to the requester.
interface period_meter_if #(
    parameter int CNT_W = 20
);
    logic             sig_in;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [2:0]       decade;
    logic             match;
    logic             valid;
    logic             busy;
    logic             timeout;

    modport master (
        output sig_in, start, cont,
        input  period, high_time, decade, match, valid, busy, timeout
    );

    modport slave (
        input  sig_in, start, cont,
        output period, high_time, decade, match, valid, busy, timeout
    );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of sig_in in clk_in cycles and maps the result onto
// the frequency selector's decade code; single-shot or continuous, with edge timeouts.
module period_meter #(
    parameter int          CNT_W   = 20,
    parameter int unsigned TIMEOUT = 1048575
) (
    input  logic         clk_in,
    input  logic         rst_n,
    period_meter_if.slave bus
);
    localparam int unsigned     WCW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WLIM    = WCW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int unsigned     DEC_P [7] = '{2, 10, 100, 1000, 10000, 100000, 1000000};

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [WCW-1:0]   r_wcnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cap;
    logic             r_fell;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic [2:0]       r_decade;
    logic             r_match;
    logic             r_valid;
    logic             r_busy;
    logic             r_timeout;

    logic w_rise, w_fall, w_cnt_to;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_fall   = ~r_s2 & r_s3;
    assign w_cnt_to = (32'(r_cnt) >= TIMEOUT);

    // Returns {match, decade}; only an exact 50% duty at a decade period matches.
    function automatic logic [3:0] classify(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
        logic [3:0] res;
        res = {1'b0, 3'd7};
        for (int k = 0; k < 7; k++)
            if (32'(p) == DEC_P[k] && 32'(h) == DEC_P[k] / 2)
                res = {1'b1, 3'(k)};
        return res;
    endfunction

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_wcnt      <= '0;
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_fell      <= 1'b0;
            r_period    <= '0;
            r_high_time <= '0;
            r_decade    <= 3'd0;
            r_match     <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_s1      <= bus.sig_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= ARM;
                        r_wcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        r_state  <= MEASURE;
                        r_cnt    <= CNT_W'(1);
                        r_hi_cap <= '0;
                        r_fell   <= 1'b0;
                    end else if (r_wcnt == WLIM) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_period               <= r_cnt;
                        r_high_time            <= r_hi_cap;
                        {r_match, r_decade}    <= classify(r_cnt, r_hi_cap);
                        r_valid                <= 1'b1;
                        // The closing edge doubles as the next opening edge in continuous mode.
                        r_cnt                  <= CNT_W'(1);
                        r_hi_cap               <= '0;
                        r_fell                 <= 1'b0;
                        if (!bus.cont) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_cnt_to) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        if (r_cnt != CNT_MAX)
                            r_cnt <= r_cnt + 1'b1;
                        if (w_fall && !r_fell) begin
                            r_hi_cap <= r_cnt;
                            r_fell   <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high_time;
    assign bus.decade    = r_decade;
    assign bus.match     = r_match;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.timeout   = r_timeout;
endmodule
